// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage constants, opcode encodings and buffer entry type.
// Included by fetch_stage and fetch_skid_buffer.
package fetch_stage_pkg;

   localparam logic [31:0] FETCH_RESET_PC  = 32'h4000_0000;
   localparam logic [31:0] FETCH_NOP_INSTR = 32'h0000_0013;

   typedef enum logic [6:0] {
      OP_LUI    = 7'b0110111,
      OP_AUIPC  = 7'b0010111,
      OP_JAL    = 7'b1101111,
      OP_JALR   = 7'b1100111,
      OP_BRANCH = 7'b1100011,
      OP_LOAD   = 7'b0000011,
      OP_STORE  = 7'b0100011,
      OP_IMM    = 7'b0010011,
      OP_REG    = 7'b0110011
   } opcode_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// Two-entry FIFO of {pc, instr} between the imem response and decode.
// Entry 0 is always the head; flush takes priority over push/pop.
module fetch_skid_buffer
   import fetch_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        push,
   input  logic        pop,
   input  logic        flush,
   input  logic [31:0] push_pc,
   input  logic [31:0] push_instr,
   output logic [1:0]  count,
   output logic [31:0] head_pc,
   output logic [31:0] head_instr
);

   fetch_entry_t entry0, entry1, wr_entry;

   assign wr_entry   = '{pc: push_pc, instr: push_instr};
   assign head_pc    = entry0.pc;
   assign head_instr = entry0.instr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count  <= 2'd0;
         entry0 <= '0;
         entry1 <= '0;
      end else if (flush) begin
         count <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count == 2'd0) entry0 <= wr_entry;
               else               entry1 <= wr_entry;
               count <= count + 2'd1;
            end
            2'b01: begin
               entry0 <= entry1;
               count  <= count - 2'd1;
            end
            2'b11: begin
               // count unchanged; the new word lands behind whatever remains
               if (count == 2'd1) begin
                  entry0 <= wr_entry;
               end else begin
                  entry0 <= entry1;
                  entry1 <= wr_entry;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch front end: PC, one-outstanding imem requests, skid buffer to decode.
// Build with FETCH_PERF_CNT_EN to add the instruction/bubble performance counters.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = FETCH_RESET_PC,
   parameter logic [31:0] NOP_INSTR = FETCH_NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        bubble
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] perf_instr_cnt,
   output logic [31:0] perf_bubble_cnt
`endif
);

   logic        run;
   logic        outstanding;
   logic        kill;
   logic [31:0] pc;
   logic [31:0] req_pc;
   logic [1:0]  count;
   logic [31:0] head_pc;
   logic [31:0] head_instr;
   logic        resp;
   logic        pop;
   logic        push;
   logic        accept;
   logic [2:0]  occ_after_pop;

   // Responses with nothing outstanding (e.g. left over from before reset) are ignored.
   assign resp          = imem_resp_valid && outstanding;
   assign bubble        = (count == 2'd0);
   assign pop           = !bubble && !stall;
   assign push          = resp && !kill && !redirect;
   assign occ_after_pop = {1'b0, count} + {2'b00, outstanding} - {2'b00, pop};

   assign imem_req_valid = run && !redirect && (occ_after_pop <= 3'd1) && (!outstanding || resp);
   assign imem_addr      = pc;
   assign accept         = imem_req_valid && imem_req_ready;

   assign instr    = bubble ? NOP_INSTR : head_instr;
   assign instr_pc = bubble ? 32'h0 : head_pc;

   fetch_skid_buffer u_skid (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push),
      .pop        (pop),
      .flush      (redirect),
      .push_pc    (req_pc),
      .push_instr (imem_resp_data),
      .count      (count),
      .head_pc    (head_pc),
      .head_instr (head_instr)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run         <= 1'b0;
         pc          <= RESET_PC;
         req_pc      <= 32'h0;
         outstanding <= 1'b0;
         kill        <= 1'b0;
      end else begin
         run <= 1'b1;
         if (redirect) begin
            // an in-flight request whose answer has not arrived must be dropped later
            pc          <= word_align(redirect_pc);
            kill        <= outstanding && !resp;
            outstanding <= outstanding && !resp;
         end else begin
            if (accept) begin
               pc          <= pc + 32'd4;
               req_pc      <= pc;
               outstanding <= 1'b1;
            end else if (resp) begin
               outstanding <= 1'b0;
            end
            if (resp && kill) kill <= 1'b0;
         end
      end
   end

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_instr_cnt  <= 32'h0;
         perf_bubble_cnt <= 32'h0;
      end else begin
         if (pop)              perf_instr_cnt  <= perf_instr_cnt + 32'd1;
         if (bubble && !stall) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      end
   end
`endif

endmodule
